// File: rtl/reg_file_pkg.sv
// Shared sizing constants for the integer register file.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int ZERO_REG     = 0;

endpackage

// File: rtl/reg_file_reg_32bit_en.sv
// One architectural register: async active-low clear, load enable.
import reg_file_pkg::*;

module reg_32bit_en #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with hardwired zero register
// and optional same-cycle write-to-read forwarding.
import reg_file_pkg::*;

module reg_file #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0][DATA_W-1:0] q;
    logic [NUM_REGS-1:1]             wen;
    logic                            wr_live;
    logic                            hit1;
    logic                            hit2;

    // Register 0 has no enable, so the decode starts at index 1.
    always_comb begin
        wen = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            wen[i] = we && (waddr == ADDR_W'(i));
        end
    end

    assign q[ZERO_REG] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
        reg_32bit_en #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk  (clk),
            .reset(reset),
            .en   (wen[i]),
            .d    (wdata),
            .q    (q[i])
        );
    end

    assign wr_live = (BYPASS != 0) && reset && we && (waddr != ZADDR);
    assign hit1    = wr_live && (raddr1 == waddr);
    assign hit2    = wr_live && (raddr2 == waddr);

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (reset) begin
            rdata1 = hit1 ? wdata : q[raddr1];
            rdata2 = hit2 ? wdata : q[raddr2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench: directed scenarios plus random traffic against an array model.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] nb_rdata1;
    logic [31:0] nb_rdata2;

    logic [31:0] model [32];
    int          n_chk;
    int          n_fail;

    reg_file #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
    );

    reg_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (reset !== 1'b1) return 32'h0;
        if (byp && we && waddr != 5'd0 && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, "_r1"}, rdata1, exp_rd(raddr1, 1'b1));
        chk({tag, "_r2"}, rdata2, exp_rd(raddr2, 1'b1));
        chk({tag, "_nb_r1"}, nb_rdata1, exp_rd(raddr1, 1'b0));
        chk({tag, "_nb_r2"}, nb_rdata2, exp_rd(raddr2, 1'b0));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset && we && waddr != 5'd0) model[waddr] = wdata;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        foreach (model[i]) model[i] = 32'h0;
        reset = 1'b1;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr1 = '0;
        raddr2 = '0;
        #2 reset = 1'b0;

        // Reset held: writes ignored, every address reads zero.
        for (int i = 0; i < 32; i++) begin
            we = 1'b1;
            waddr = 5'(i);
            wdata = $urandom;
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            chk("rst_r1", rdata1, 32'h0);
            chk("rst_r2", rdata2, 32'h0);
            chk("rst_nb_r1", nb_rdata1, 32'h0);
            if (i % 8 == 7) step();
        end
        @(negedge clk);
        we = 1'b0;
        reset = 1'b1;
        #1;
        chk_all("post_rst");

        wr(5'd5, 32'hAFAFAFAF);
        raddr1 = 5'd5;
        #1;
        chk("x5_r1", rdata1, 32'hAFAFAFAF);
        chk("x5_nb_r1", nb_rdata1, 32'hAFAFAFAF);

        // Zero register ignores writes, even under bypass.
        we = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFFFFFF;
        raddr1 = 5'd0;
        #1;
        chk("x0_wcyc", rdata1, 32'h0);
        step();
        we = 1'b0;
        #1;
        chk("x0_after", rdata1, 32'h0);
        chk("x0_after_nb", nb_rdata1, 32'h0);

        wr(5'd3, 32'h12345678);
        wr(5'd7, 32'hDEADBEEF);
        raddr1 = 5'd3;
        raddr2 = 5'd7;
        #1;
        chk("dual_r1", rdata1, 32'h12345678);
        chk("dual_r2", rdata2, 32'hDEADBEEF);
        raddr1 = 5'd7;
        #1;
        chk("same_r1", rdata1, 32'hDEADBEEF);
        chk("same_r2", rdata2, 32'hDEADBEEF);

        wr(5'd9, 32'h1);
        we = 1'b1;
        waddr = 5'd9;
        wdata = 32'h2;
        raddr1 = 5'd9;
        #1;
        chk("byp_same", rdata1, 32'h2);
        chk("nobyp_same", nb_rdata1, 32'h1);
        step();
        we = 1'b0;
        #1;
        chk("byp_after", rdata1, 32'h2);
        chk("nobyp_after", nb_rdata1, 32'h2);

        // Reset pulsed between edges while a write to x4 is pending.
        wr(5'd4, 32'hCAFEF00D);
        raddr1 = 5'd4;
        raddr2 = 5'd5;
        #1;
        chk("x4_set", rdata1, 32'hCAFEF00D);
        we = 1'b1;
        waddr = 5'd4;
        wdata = 32'h55AA55AA;
        #1;
        reset = 1'b0;
        foreach (model[i]) model[i] = 32'h0;
        #1;
        chk("midrst_r1", rdata1, 32'h0);
        chk("midrst_r2", rdata2, 32'h0);
        chk("midrst_nb", nb_rdata1, 32'h0);
        step();
        we = 1'b0;
        reset = 1'b1;
        #1;
        chk("x4_lost", rdata1, 32'h0);
        chk("x5_cleared", rdata2, 32'h0);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) ^ 32'hA5A5A5A5);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            chk("exh_r1", rdata1, (i == 0) ? 32'h0 : (32'(i) ^ 32'hA5A5A5A5));
            chk("exh_r2", rdata2, (i == 31) ? 32'h0 : (32'(31 - i) ^ 32'hA5A5A5A5));
        end

        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            #1;
            chk_all("rnd");
            step();
        end
        we = 1'b0;
        #1;
        chk_all("rnd_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
